// File: rtl/spi_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_tx_arbiter_pkg
// Brief   : Shared widths and FSM state encoding for the SPI TX arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package spi_tx_arbiter_pkg;

  localparam int WORD_W = 16;
  localparam int LEN_W  = 8;
  localparam int ST_W   = 3;

  localparam logic [ST_W-1:0] c_ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] c_ST_LOAD      = 3'd1;
  localparam logic [ST_W-1:0] c_ST_WAIT_FREE = 3'd2;
  localparam logic [ST_W-1:0] c_ST_SEND      = 3'd3;
  localparam logic [ST_W-1:0] c_ST_WAIT_ACK  = 3'd4;
  localparam logic [ST_W-1:0] c_ST_WAIT_DONE = 3'd5;
  localparam logic [ST_W-1:0] c_ST_FINISH    = 3'd6;

endpackage
`default_nettype wire

// File: rtl/spi_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : spi_tx_arbiter_rr_pick
// Brief   : Combinational round-robin pick: first set request at/after pointer.
// Revision: 1.0 - initial release
// ============================================================================
module spi_tx_arbiter_rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_idx,
  output logic [N-1:0]     o_onehot,
  output logic             o_valid
);

  logic             w_hit_hi;
  logic             w_hit_any;
  logic [PTR_W-1:0] w_idx_hi;
  logic [PTR_W-1:0] w_idx_lo;

  // Descending scan: the last hit written is the lowest index, so w_idx_hi is the
  // first request at/after the pointer and w_idx_lo the wrap-around fallback.
  always_comb begin
    w_hit_hi  = 1'b0;
    w_hit_any = 1'b0;
    w_idx_hi  = '0;
    w_idx_lo  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_hit_any = 1'b1;
        w_idx_lo  = PTR_W'(i);
        if (PTR_W'(i) >= i_ptr) begin
          w_hit_hi = 1'b1;
          w_idx_hi = PTR_W'(i);
        end
      end
    end
  end

  assign o_valid  = w_hit_any;
  assign o_idx    = w_hit_hi ? w_idx_hi : w_idx_lo;
  assign o_onehot = w_hit_any ? (N'(1) << o_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : spi_tx_arbiter
// Brief   : Round-robin sequencer sharing one SPI TX path between message sources.
// Revision: 1.0 - initial release
// ============================================================================
module spi_tx_arbiter
  import spi_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                      SYS_CLK,
  input  logic                      RST,
  input  logic [NUM_SRC-1:0]        SRC_REQ,
  input  logic [LEN_W*NUM_SRC-1:0]  SRC_LEN,
  input  logic [WORD_W*NUM_SRC-1:0] SRC_DATA,
  output logic [NUM_SRC-1:0]        SRC_RD,
  output logic [NUM_SRC-1:0]        SRC_DONE,
  output logic [NUM_SRC-1:0]        GRANT,
  output logic [WORD_W-1:0]         DATA,
  output logic                      ENA,
  input  logic                      BUSY,
  output logic                      TIMEOUT_ERR
);

  localparam int               PTR_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [LEN_W-1:0] c_TMO_LAST = LEN_W'(ACK_TIMEOUT - 1);
  localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(NUM_SRC - 1);

  logic [ST_W-1:0]    r_state;
  logic [ST_W-1:0]    w_next;
  logic               r_busy_meta;
  logic               r_busy_s;
  logic [NUM_SRC-1:0] r_grant;
  logic [PTR_W-1:0]   r_sel;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [LEN_W-1:0]   r_words_left;
  logic [LEN_W-1:0]   r_tmo_cnt;
  logic [WORD_W-1:0]  r_data;
  logic               r_timeout_err;

  logic [PTR_W-1:0]   w_pick_idx;
  logic [NUM_SRC-1:0] w_pick_onehot;
  logic               w_pick_valid;
  logic [LEN_W-1:0]   w_len  [NUM_SRC];
  logic [WORD_W-1:0]  w_word [NUM_SRC];
  logic [LEN_W-1:0]   w_sel_len;
  logic [WORD_W-1:0]  w_sel_word;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign w_len[g]  = SRC_LEN[g*LEN_W +: LEN_W];
    assign w_word[g] = SRC_DATA[g*WORD_W +: WORD_W];
  end

  assign w_sel_len  = w_len[r_sel];
  assign w_sel_word = w_word[r_sel];

  spi_tx_arbiter_rr_pick #(
    .N     (NUM_SRC),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req    (SRC_REQ),
    .i_ptr    (r_rr_ptr),
    .o_idx    (w_pick_idx),
    .o_onehot (w_pick_onehot),
    .o_valid  (w_pick_valid)
  );

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_busy_meta <= 1'b0;
      r_busy_s    <= 1'b0;
    end else begin
      r_busy_meta <= BUSY;
      r_busy_s    <= r_busy_meta;
    end
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:      if (w_pick_valid) w_next = c_ST_LOAD;
      c_ST_LOAD:      w_next = (w_sel_len == '0) ? c_ST_FINISH : c_ST_WAIT_FREE;
      c_ST_WAIT_FREE: if (!r_busy_s) w_next = c_ST_SEND;
      c_ST_SEND:      w_next = c_ST_WAIT_ACK;
      c_ST_WAIT_ACK: begin
        if (r_busy_s) begin
          w_next = c_ST_WAIT_DONE;
        end else if (r_tmo_cnt == c_TMO_LAST) begin
          w_next = c_ST_FINISH;
        end
      end
      c_ST_WAIT_DONE: begin
        if (!r_busy_s) begin
          w_next = (r_words_left == '0) ? c_ST_FINISH : c_ST_WAIT_FREE;
        end
      end
      c_ST_FINISH:    w_next = c_ST_IDLE;
      default:        w_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    ENA      = (r_state == c_ST_SEND);
    SRC_RD   = ENA ? r_grant : '0;
    SRC_DONE = (r_state == c_ST_FINISH) ? r_grant : '0;
  end

  assign GRANT       = r_grant;
  assign DATA        = r_data;
  assign TIMEOUT_ERR = r_timeout_err;

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_grant       <= '0;
      r_sel         <= '0;
      r_rr_ptr      <= '0;
      r_words_left  <= '0;
      r_tmo_cnt     <= '0;
      r_data        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_pick_onehot;
            r_sel   <= w_pick_idx;
          end
        end
        c_ST_LOAD: r_words_left <= w_sel_len;
        // DATA is captured on entry to SEND so it is valid alongside ENA.
        c_ST_WAIT_FREE: if (!r_busy_s) r_data <= w_sel_word;
        c_ST_SEND: begin
          r_words_left <= r_words_left - 1'b1;
          r_tmo_cnt    <= '0;
        end
        c_ST_WAIT_ACK: begin
          if (!r_busy_s) begin
            if (r_tmo_cnt == c_TMO_LAST) begin
              r_timeout_err <= 1'b1;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
          end
        end
        c_ST_FINISH: begin
          r_grant  <= '0;
          r_rr_ptr <= (r_sel == c_PTR_LAST) ? '0 : r_sel + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_tx_arbiter
// Brief   : Directed bench with source/BUSY models and a per-cycle message-level checker.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_tx_arbiter;

  localparam int N   = 2;
  localparam int TMO = 255;

  logic            SYS_CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    SRC_REQ;
  logic [8*N-1:0]  SRC_LEN;
  logic [16*N-1:0] SRC_DATA;
  logic [N-1:0]    SRC_RD;
  logic [N-1:0]    SRC_DONE;
  logic [N-1:0]    GRANT;
  logic [15:0]     DATA;
  logic            ENA;
  logic            BUSY;
  logic            TIMEOUT_ERR;

  spi_tx_arbiter #(.NUM_SRC(N), .ACK_TIMEOUT(TMO)) dut (
    .SYS_CLK     (SYS_CLK),
    .RST         (RST),
    .SRC_REQ     (SRC_REQ),
    .SRC_LEN     (SRC_LEN),
    .SRC_DATA    (SRC_DATA),
    .SRC_RD      (SRC_RD),
    .SRC_DONE    (SRC_DONE),
    .GRANT       (GRANT),
    .DATA        (DATA),
    .ENA         (ENA),
    .BUSY        (BUSY),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  initial forever #5 SYS_CLK = ~SYS_CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Source and BUSY model state
  logic [15:0] src_q [N][$];
  logic [15:0] exp_q [N][$];
  int          post_len  [N];
  bit          post_pend [N];
  bit          busy_stuck = 1'b0;
  int          busy_hi    = 10;
  int          bsy_on = 0, bsy_off = 0;
  logic [N-1:0] pend_rd, pend_done;

  // Checker state and logs
  int          ncyc = 0;
  int          ptr = 0, owner = 0, sent = 0;
  logic [N-1:0] prev_grant, prev_done, prev_req;
  logic        prev_err;
  logic [15:0] last_data;
  logic [15:0] ena_log [$];
  int          ena_cyc [$];
  logic [N-1:0] grant_log [$];
  int          rd_cnt [N];
  int          done_cnt [N];
  int          t_req, t_grant, t_done, t_err;

  function automatic int rr_expect(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic clear_logs();
    ena_log.delete(); ena_cyc.delete(); grant_log.delete();
    for (int s = 0; s < N; s++) begin rd_cnt[s] = 0; done_cnt[s] = 0; end
    t_req = -1; t_grant = -1; t_done = -1; t_err = -1;
  endtask

  task automatic post(input int s, input int len, input logic [15:0] base);
    src_q[s].delete(); exp_q[s].delete();
    for (int k = 0; k < len; k++) begin
      src_q[s].push_back(base + 16'(k));
      exp_q[s].push_back(base + 16'(k));
    end
    post_len[s]  = len;
    post_pend[s] = 1'b1;
  endtask

  task automatic tick();
    @(negedge SYS_CLK); #1;
  endtask

  // Compare at negedge, then update the source/BUSY models just after posedge.
  initial begin
    logic err_rise;
    int   w;
    forever begin
      @(negedge SYS_CLK);
      ncyc++;
      if (!RST) begin
        ptr = 0; owner = 0; sent = 0; last_data = '0;
        prev_grant = '0; prev_done = '0; prev_req = '0; prev_err = 1'b0;
        pend_rd = '0; pend_done = '0;
      end else begin
        err_rise = TIMEOUT_ERR && !prev_err;
        check("grant_onehot0", 32'($onehot0(GRANT)), 1);
        check("rd_equals_grant_on_ena", 32'(SRC_RD), ENA ? 32'(GRANT) : 0);
        if ((SRC_REQ & ~prev_req) != '0) t_req = ncyc;
        if (prev_grant != '0 && GRANT != prev_grant)
          check("grant_change_only_after_done", 32'(GRANT == '0 && prev_done == prev_grant), 1);
        if (prev_done != '0) check("grant_clear_after_done", 32'(GRANT), 0);
        if (prev_grant == '0 && GRANT != '0) begin
          w = rr_expect(prev_req, ptr);
          check("rr_grant", 32'(GRANT), 32'(1) << w);
          owner = w; sent = 0; t_grant = ncyc;
          grant_log.push_back(GRANT);
        end
        if (ENA) begin
          check("busy_low_at_ena", 32'(BUSY), 0);
          check("ena_has_pending_word", 32'(exp_q[owner].size() > 0), 1);
          if (exp_q[owner].size() > 0) check("ena_data", 32'(DATA), 32'(exp_q[owner].pop_front()));
          sent++;
          ena_log.push_back(DATA); ena_cyc.push_back(ncyc);
          last_data = DATA;
          if (!busy_stuck) begin bsy_on = ncyc; bsy_off = ncyc + busy_hi; end
        end else begin
          check("data_hold", 32'(DATA), 32'(last_data));
        end
        for (int s = 0; s < N; s++) if (SRC_RD[s]) rd_cnt[s]++;
        if (prev_err) check("timeout_err_sticky", 32'(TIMEOUT_ERR), 1);
        if (err_rise) begin
          t_err = ncyc;
          check("abort_done_with_err", 32'(SRC_DONE), 32'(GRANT));
        end
        if (SRC_DONE != '0) begin
          check("done_matches_grant", 32'(SRC_DONE), 32'(GRANT));
          if (!err_rise) check("done_after_all_words", sent, post_len[owner]);
          for (int s = 0; s < N; s++) if (SRC_DONE[s]) done_cnt[s]++;
          exp_q[owner].delete();
          ptr = (owner + 1) % N;
          t_done = ncyc;
        end
        pend_rd = SRC_RD; pend_done = SRC_DONE;
        prev_grant = GRANT; prev_done = SRC_DONE; prev_req = SRC_REQ; prev_err = TIMEOUT_ERR;
      end
      @(posedge SYS_CLK); #1;
      if (!RST) begin
        SRC_REQ = '0; BUSY = 1'b0; bsy_on = 0; bsy_off = 0;
        for (int s = 0; s < N; s++) begin src_q[s].delete(); exp_q[s].delete(); post_pend[s] = 1'b0; end
      end else begin
        for (int s = 0; s < N; s++) begin
          if (pend_rd[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
          if (pend_done[s]) begin SRC_REQ[s] = 1'b0; src_q[s].delete(); end
          if (post_pend[s]) begin
            SRC_REQ[s] = 1'b1;
            SRC_LEN[s*8 +: 8] = 8'(post_len[s]);
            post_pend[s] = 1'b0;
          end
          SRC_DATA[s*16 +: 16] = (src_q[s].size() > 0) ? src_q[s][0] : 16'h0;
        end
        BUSY = (ncyc >= bsy_on) && (ncyc < bsy_off);
      end
    end
  end

  task automatic wait_done(input int s, input int target, input int budget);
    int n = 0;
    while (done_cnt[s] < target && n < budget) begin tick(); n++; end
    check("wait_done_in_budget", 32'(done_cnt[s] >= target), 1);
  endtask

  task automatic wait_ena(input int target, input int budget);
    int n = 0;
    while (ena_log.size() < target && n < budget) begin tick(); n++; end
    check("wait_ena_in_budget", 32'(ena_log.size() >= target), 1);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    int done0;
    SRC_REQ = '0; SRC_LEN = '0; SRC_DATA = '0; BUSY = 1'b0;
    for (int s = 0; s < N; s++) post_pend[s] = 1'b0;
    clear_logs();
    RST = 1'b1;
    #1 RST = 1'b0;
    #1;
    check("reset_grant", 32'(GRANT), 0);
    check("reset_ena", 32'(ENA), 0);
    check("reset_src_rd", 32'(SRC_RD), 0);
    check("reset_src_done", 32'(SRC_DONE), 0);
    check("reset_data", 32'(DATA), 0);
    check("reset_timeout_err", 32'(TIMEOUT_ERR), 0);
    repeat (3) tick();
    RST = 1'b1;
    repeat (2) tick();

    // 1: single source, three words
    clear_logs();
    post(0, 3, 16'h00A1);
    wait_done(0, 1, 200);
    check("t1_ena_count", ena_log.size(), 3);
    check("t1_word1", 32'(ena_log[0]), 32'h00A1);
    check("t1_word2", 32'(ena_log[1]), 32'h00A2);
    check("t1_word3", 32'(ena_log[2]), 32'h00A3);
    check("t1_rd_count", rd_cnt[0], 3);
    check("t1_done_count", done_cnt[0], 1);
    check("t1_req_to_first_ena", ena_cyc[0] - t_req, 3);
    repeat (3) tick();

    // 2: both request together after reset
    do_reset();
    clear_logs();
    post(0, 1, 16'h0C01);
    post(1, 1, 16'h0C02);
    wait_done(1, 1, 200);
    check("t2_grant_count", grant_log.size(), 2);
    check("t2_first_grant", 32'(grant_log[0]), 32'h1);
    check("t2_second_grant", 32'(grant_log[1]), 32'h2);
    check("t2_first_word", 32'(ena_log[0]), 32'h0C01);
    check("t2_second_word", 32'(ena_log[1]), 32'h0C02);
    repeat (3) tick();

    // 3: pointer wraps after src1; a just-served source goes last
    clear_logs();
    post(0, 1, 16'h0E01);
    post(1, 1, 16'h0E02);
    wait_done(1, 1, 200);
    check("t3_wrap_src0_first", 32'(grant_log[0]), 32'h1);
    repeat (3) tick();
    clear_logs();
    post(0, 1, 16'h0E03);
    wait_done(0, 1, 200);
    repeat (3) tick();
    clear_logs();
    post(0, 1, 16'h0E04);
    post(1, 1, 16'h0E05);
    wait_done(0, 1, 200);
    check("t3_src0_not_twice", 32'(grant_log[0]), 32'h2);
    check("t3_then_src0", 32'(grant_log[1]), 32'h1);
    repeat (3) tick();

    // 4: empty message
    clear_logs();
    post(0, 0, 16'h0000);
    wait_done(0, 1, 50);
    check("t4_done_latency", t_done - t_req, 2);
    check("t4_grant_latency", t_grant - t_req, 1);
    check("t4_no_ena", ena_log.size(), 0);
    check("t4_no_rd", rd_cnt[0], 0);
    repeat (3) tick();

    // 5: BUSY never rises; 255 WAIT_ACK cycles follow ENA, flag shows the cycle after
    clear_logs();
    busy_stuck = 1'b1;
    post(0, 2, 16'h0D01);
    wait_done(0, 1, 400);
    check("t5_one_ena", ena_log.size(), 1);
    check("t5_one_rd", rd_cnt[0], 1);
    check("t5_err_timing", t_err - ena_cyc[0], TMO + 1);
    check("t5_done_with_err", t_done, t_err);
    repeat (3) tick();
    check("t5_idle_grant", 32'(GRANT), 0);
    check("t5_err_held", 32'(TIMEOUT_ERR), 1);
    busy_stuck = 1'b0;

    // 6: async reset while word 2 of 4 is shifting
    clear_logs();
    post(0, 4, 16'hB001);
    wait_ena(2, 100);
    repeat (6) tick();
    check("t6_owned_before_reset", 32'(GRANT), 32'h1);
    done0 = done_cnt[0];
    #2 RST = 1'b0;
    #1;
    check("t6_async_grant", 32'(GRANT), 0);
    check("t6_async_ena", 32'(ENA), 0);
    check("t6_async_rd", 32'(SRC_RD), 0);
    check("t6_async_data", 32'(DATA), 0);
    check("t6_async_err", 32'(TIMEOUT_ERR), 0);
    repeat (3) tick();
    RST = 1'b1;
    repeat (2) tick();
    check("t6_no_done_on_reset", done_cnt[0], done0);
    clear_logs();
    post(0, 4, 16'hB001);
    wait_done(0, 1, 200);
    check("t6_ena_count", ena_log.size(), 4);
    check("t6_restart_word1", 32'(ena_log[0]), 32'hB001);
    check("t6_last_word", 32'(ena_log[3]), 32'hB004);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
